// File: rtl/gemv_prealign_arbiter.sv
// Round-robin arbiter sharing one GEMV pre-align datapath between NUM_REQ requesters,
// with in-order tag FIFO for result routing. Optional perf counters: GEMV_ARB_PERF_CNT_EN.
module gemv_prealign_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int REQ_DATA_WIDTH = 8192,
  parameter int RSP_DATA_WIDTH = 4864,
  parameter int MAX_INFLIGHT   = 8,
  parameter int IDX_W          = $clog2(NUM_REQ),
  parameter int CNT_W          = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ*REQ_DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]                req_vld,
  output logic [NUM_REQ-1:0]                req_rdy,
  output logic [REQ_DATA_WIDTH-1:0]         dp_data_wr,
  output logic                              dp_data_wr_vld,
  input  logic                              dp_data_wr_rdy,
  input  logic [RSP_DATA_WIDTH-1:0]         dp_rsp_data,
  input  logic                              dp_rsp_vld,
  output logic                              dp_rsp_rdy,
  output logic [RSP_DATA_WIDTH-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]                rsp_vld,
  input  logic [NUM_REQ-1:0]                rsp_rdy,
  output logic [CNT_W-1:0]                  inflight_cnt,
  output logic                              protocol_err
`ifdef GEMV_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*32-1:0]             issue_cnt,
  output logic [31:0]                       full_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(MAX_INFLIGHT);

  // state   | meaning
  // ST_ARB  | grant follows round-robin search over req_vld
  // ST_LOCK | offer stalled by datapath; grant frozen on locked_idx
  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, locked_idx, search_idx, grant_idx, head;
  logic             lock, any_vld, found, fifo_full, fifo_empty, issue, pop;
  logic [IDX_W-1:0] tag_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  int               cand;

  assign any_vld    = |req_vld;
  assign lock       = (state == ST_LOCK);
  assign fifo_full  = (cnt == CNT_W'(MAX_INFLIGHT));
  assign fifo_empty = (cnt == '0);
  assign head       = tag_mem[rd_ptr];

  always_comb begin
    search_idx = rr_ptr;
    found      = 1'b0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_vld[IDX_W'(cand)]) begin
        found      = 1'b1;
        search_idx = IDX_W'(cand);
      end
    end
  end

  assign grant_idx      = lock ? locked_idx : search_idx;
  assign dp_data_wr_vld = (lock | any_vld) & ~fifo_full;
  assign issue          = dp_data_wr_vld & dp_data_wr_rdy;

  always_comb begin
    dp_data_wr = '0;
    req_rdy    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (dp_data_wr_vld && grant_idx == IDX_W'(i))
        dp_data_wr = req_data[i*REQ_DATA_WIDTH +: REQ_DATA_WIDTH];
    end
    if (issue) req_rdy[grant_idx] = 1'b1;
  end

  always_comb begin
    rsp_vld = '0;
    if (dp_rsp_vld && !fifo_empty) rsp_vld[head] = 1'b1;
  end

  assign dp_rsp_rdy   = ~fifo_empty & rsp_rdy[head];
  assign pop          = dp_rsp_vld & dp_rsp_rdy;
  assign rsp_data     = dp_rsp_data;
  assign inflight_cnt = cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:  if (dp_data_wr_vld && !dp_data_wr_rdy) state_nxt = ST_LOCK;
      ST_LOCK: if (issue) state_nxt = ST_ARB;
      default: state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_ARB;
      rr_ptr     <= '0;
      locked_idx <= '0;
    end else begin
      state <= state_nxt;
      if (issue)
        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (state == ST_ARB && dp_data_wr_vld && !dp_data_wr_rdy)
        locked_idx <= grant_idx;
    end
  end

  // Tag storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (issue) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({issue, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (dp_rsp_vld && fifo_empty) protocol_err <= 1'b1;
    end
  end

`ifdef GEMV_ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt      <= '0;
      full_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (issue && grant_idx == IDX_W'(i))
          issue_cnt[i*32 +: 32] <= issue_cnt[i*32 +: 32] + 32'd1;
      end
      if ((any_vld | lock) && fifo_full)
        full_stall_cnt <= full_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gemv_prealign_arbiter.sv
// Directed bench for gemv_prealign_arbiter: queue-based reference model checked every
// cycle plus hand-computed expectations per scenario. GEMV_ARB_PERF_CNT_EN adds counter checks.
module tb_gemv_prealign_arbiter;
  localparam int N  = 4;
  localparam int RW = 64;
  localparam int SW = 48;
  localparam int MI = 8;
  localparam int CW = $clog2(MI) + 1;

  logic            clk, rst;
  logic [N*RW-1:0] req_data;
  logic [N-1:0]    req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [RW-1:0]   dp_data_wr;
  logic            dp_data_wr_vld, dp_data_wr_rdy, dp_rsp_vld, dp_rsp_rdy, protocol_err;
  logic [SW-1:0]   dp_rsp_data, rsp_data;
  logic [CW-1:0]   inflight_cnt;
`ifdef GEMV_ARB_PERF_CNT_EN
  logic [N*32-1:0] issue_cnt;
  logic [31:0]     full_stall_cnt;
`endif

  gemv_prealign_arbiter #(
    .NUM_REQ(N), .REQ_DATA_WIDTH(RW), .RSP_DATA_WIDTH(SW), .MAX_INFLIGHT(MI)
  ) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_vld(req_vld), .req_rdy(req_rdy),
    .dp_data_wr(dp_data_wr), .dp_data_wr_vld(dp_data_wr_vld), .dp_data_wr_rdy(dp_data_wr_rdy),
    .dp_rsp_data(dp_rsp_data), .dp_rsp_vld(dp_rsp_vld), .dp_rsp_rdy(dp_rsp_rdy),
    .rsp_data(rsp_data), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .inflight_cnt(inflight_cnt), .protocol_err(protocol_err)
`ifdef GEMV_ARB_PERF_CNT_EN
    , .issue_cnt(issue_cnt), .full_stall_cnt(full_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Stimulus state
  logic [RW-1:0] pay [N];
  int            rem [N];
  int            seq;
  bit            dp_rsp_en, force_rsp;
  logic [RW-1:0] dp_q [$];
  int            issue_log [$];
  int            rsp_log [$];
  logic [N-1:0]  s_req_rdy, s_rsp_vld;
  logic          s_dvld, s_dprdy;
  logic [RW-1:0] s_ddata;

  function automatic logic [SW-1:0] rsp_fn(input logic [RW-1:0] p);
    logic [SW-1:0] k;
    k = 48'h5A5A_0F0F_3C3C;
    return p[SW-1:0] ^ k;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_data[i*RW +: RW] = pay[i];
      req_vld[i] = (rem[i] > 0);
    end
    dp_rsp_vld  = force_rsp | (dp_rsp_en && dp_q.size() > 0);
    dp_rsp_data = (dp_q.size() > 0) ? rsp_fn(dp_q[0]) : '0;
  endtask

  task automatic cyc();
    logic acc, popd;
    @(negedge clk);
    s_req_rdy = req_rdy;  s_dvld = dp_data_wr_vld;  s_ddata = dp_data_wr;
    s_rsp_vld = rsp_vld;  s_dprdy = dp_rsp_rdy;
    acc  = dp_data_wr_vld & dp_data_wr_rdy;
    popd = dp_rsp_vld & dp_rsp_rdy;
    if (popd) begin
      void'(dp_q.pop_front());
      for (int i = 0; i < N; i++) if (rsp_vld[i]) rsp_log.push_back(i);
    end
    if (acc) dp_q.push_back(dp_data_wr);
    for (int i = 0; i < N; i++) begin
      if (req_rdy[i]) begin
        issue_log.push_back(i);
        rem[i]--;
        seq++;
        pay[i] = {8'(i), 24'hC0FFEE, 32'(seq)};
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit idle();
    bit b;
    b = (dp_q.size() == 0) && (inflight_cnt == '0);
    for (int i = 0; i < N; i++) if (rem[i] != 0) b = 0;
    return b;
  endfunction

  task automatic run_until_idle(input int budget, input string nm);
    int n;
    n = 0;
    while (!idle() && n < budget) begin
      cyc();
      n++;
    end
    chk(nm, idle(), 1);
  endtask

  // Reference model: the outstanding tags are a plain queue in issue order.
  int          m_q [$];
  int          m_rr, m_lidx;
  bit          m_lock, m_perr;
  logic [31:0] m_iss [N];
  logic [31:0] m_stall;

  always @(negedge clk) begin : model_chk
    int g, c, hd;
    bit any, full, evld, ehs, found, popm;
    logic [N-1:0]  e_req_rdy, e_rsp_vld;
    logic [RW-1:0] e_ddata;
    logic          e_dprdy;
    if (rst) begin
      m_q.delete();
      m_rr = 0; m_lidx = 0; m_lock = 0; m_perr = 0; m_stall = '0;
      for (int i = 0; i < N; i++) m_iss[i] = '0;
      chk("rst_cnt", 64'(inflight_cnt), 0);
      chk("rst_perr", 64'(protocol_err), 0);
    end else begin
      any = |req_vld;
      g = m_rr;
      if (m_lock) g = m_lidx;
      else begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (!found && req_vld[c]) begin found = 1; g = c; end
        end
      end
      full = (m_q.size() == MI);
      evld = (m_lock || any) && !full;
      ehs  = evld && dp_data_wr_rdy;
      e_req_rdy = '0;
      if (ehs) e_req_rdy[g] = 1'b1;
      e_ddata = evld ? req_data[g*RW +: RW] : '0;
      hd = (m_q.size() > 0) ? m_q[0] : 0;
      e_rsp_vld = '0;
      if (dp_rsp_vld && m_q.size() > 0) e_rsp_vld[hd] = 1'b1;
      e_dprdy = (m_q.size() > 0) && rsp_rdy[hd];
      chk("req_rdy", 64'(req_rdy), 64'(e_req_rdy));
      chk("dp_vld", 64'(dp_data_wr_vld), 64'(evld));
      chk("dp_data", 64'(dp_data_wr), 64'(e_ddata));
      chk("rsp_vld", 64'(rsp_vld), 64'(e_rsp_vld));
      chk("dp_rsp_rdy", 64'(dp_rsp_rdy), 64'(e_dprdy));
      chk("rsp_data", 64'(rsp_data), 64'(dp_rsp_data));
      chk("inflight", 64'(inflight_cnt), 64'(m_q.size()));
      chk("perr", 64'(protocol_err), 64'(m_perr));
`ifdef GEMV_ARB_PERF_CNT_EN
      for (int i = 0; i < N; i++) chk("issue_cnt", 64'(issue_cnt[i*32 +: 32]), 64'(m_iss[i]));
      chk("stall_cnt", 64'(full_stall_cnt), 64'(m_stall));
`endif
      popm = dp_rsp_vld && e_dprdy;
      if (dp_rsp_vld && m_q.size() == 0) m_perr = 1;
      if ((any || m_lock) && full) m_stall = m_stall + 1;
      if (popm) void'(m_q.pop_front());
      if (ehs) begin
        m_q.push_back(g);
        m_rr = (g + 1) % N;
        m_lock = 0;
        m_iss[g] = m_iss[g] + 1;
      end else if (evld) begin
        m_lock = 1;
        m_lidx = g;
      end
    end
  end

  initial begin
    int base, bad;
    int ids4 [3];
    logic [RW-1:0] hold2;
`ifdef GEMV_ARB_PERF_CNT_EN
    logic [31:0] stall_base;
`endif
    ids4 = '{1, 3, 0};
    rst = 1'b1; req_vld = '0; req_data = '0; rsp_rdy = '1;
    dp_data_wr_rdy = 1'b1; dp_rsp_en = 1; force_rsp = 0; seq = 0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; pay[i] = {8'(i), 24'hC0FFEE, 32'(0)}; end
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_inflight", 64'(inflight_cnt), 0);
    chk("reset_dvld", 64'(dp_data_wr_vld), 0);
    chk("reset_ddata", 64'(dp_data_wr), 0);
    chk("reset_req_rdy", 64'(req_rdy), 0);
    chk("reset_rsp_vld", 64'(rsp_vld), 0);
    rst = 1'b0;

    // Scenario 1: all requesters busy, 1-cycle datapath
    for (int i = 0; i < N; i++) rem[i] = 10;
    drive();
    base = issue_log.size();
    bad = 0;
    for (int c = 0; c < 60 && !idle(); c++) begin
      cyc();
      if (inflight_cnt > 1) bad++;
    end
    chk("s1_idle", idle(), 1);
    chk("s1_cnt_le1_viol", 64'(bad), 0);
    chk("s1_issues", 64'(issue_log.size() - base), 40);
    for (int j = 0; j < 40 && base + j < issue_log.size(); j++)
      chk("s1_order", 64'(issue_log[base + j]), 64'(j % 4));
    for (int j = 0; j < 40 && base + j < rsp_log.size(); j++)
      chk("s1_rsp_route", 64'(rsp_log[base + j]), 64'(j % 4));
`ifdef GEMV_ARB_PERF_CNT_EN
    for (int i = 0; i < N; i++) chk("s1_issue_cnt", 64'(issue_cnt[i*32 +: 32]), 10);
`endif

    // Scenario 2: lock under back-pressure
    dp_data_wr_rdy = 1'b0;
    rem[2] = 1;
    drive();
    hold2 = pay[2];
    base = issue_log.size();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin rem[0] = 1; drive(); end
      cyc();
      chk("s2_hold_data", 64'(s_ddata), 64'(hold2));
      chk("s2_hold_vld", 64'(s_dvld), 1);
      chk("s2_no_rdy", 64'(s_req_rdy), 0);
    end
    dp_data_wr_rdy = 1'b1;
    drive();
    cyc();
    chk("s2_first", 64'(s_req_rdy), 64'(4'b0100));
    cyc();
    chk("s2_second", 64'(s_req_rdy), 64'(4'b0001));
    run_until_idle(40, "s2_drain");

    // Scenario 3: responses stalled, 10 offers, FIFO fills at 8
    dp_rsp_en = 0;
    rem[0] = 3; rem[1] = 3; rem[2] = 2; rem[3] = 2;
    drive();
    base = issue_log.size();
`ifdef GEMV_ARB_PERF_CNT_EN
    stall_base = full_stall_cnt;
`endif
    repeat (14) cyc();
    chk("s3_issued", 64'(issue_log.size() - base), 8);
    chk("s3_inflight", 64'(inflight_cnt), 8);
    chk("s3_blocked", 64'(s_dvld), 0);
    for (int j = 0; j < 8 && base + j < issue_log.size(); j++)
      chk("s3_order", 64'(issue_log[base + j]), 64'((j + 1) % 4));
`ifdef GEMV_ARB_PERF_CNT_EN
    chk("s3_stall_cnt", 64'(full_stall_cnt - stall_base), 6);
`endif
    dp_rsp_en = 1;
    drive();
    cyc();
    chk("s3_full_on_pop", 64'(s_dvld), 0);
    chk("s3_pop_rdy", 64'(s_dprdy), 1);
    dp_rsp_en = 0;
    drive();
    chk("s3_freed", 64'(inflight_cnt), 7);
    cyc();
    chk("s3_reissue_vld", 64'(s_dvld), 1);
    chk("s3_reissue_who", 64'(s_req_rdy), 64'(4'b0010));
    chk("s3_refull", 64'(inflight_cnt), 8);
    dp_rsp_en = 1;
    drive();
    run_until_idle(60, "s3_drain");

    // Scenario 4: in-order routing with a stalled owner
    dp_rsp_en = 0;
    drive();
    base = rsp_log.size();
    for (int j = 0; j < 3; j++) begin
      rem[ids4[j]] = 1;
      drive();
      cyc();
      chk("s4_issue", 64'(s_req_rdy), 64'(1 << ids4[j]));
    end
    chk("s4_inflight", 64'(inflight_cnt), 3);
    rsp_rdy = 4'b1101;
    dp_rsp_en = 1;
    drive();
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("s4_hold_rdy", 64'(s_dprdy), 0);
      chk("s4_hold_vld", 64'(s_rsp_vld), 64'(4'b0010));
    end
    rsp_rdy = '1;
    drive();
    run_until_idle(20, "s4_drain");
    chk("s4_rsp_cnt", 64'(rsp_log.size() - base), 3);
    for (int j = 0; j < 3 && base + j < rsp_log.size(); j++)
      chk("s4_rsp_order", 64'(rsp_log[base + j]), 64'(ids4[j]));

    // Protocol error: response with nothing outstanding
    chk("perr_clear", 64'(protocol_err), 0);
    force_rsp = 1;
    drive();
    cyc();
    chk("perr_no_rdy", 64'(s_dprdy), 0);
    chk("perr_no_vld", 64'(s_rsp_vld), 0);
    force_rsp = 0;
    drive();
    chk("perr_set", 64'(protocol_err), 1);
    repeat (3) cyc();
    chk("perr_sticky", 64'(protocol_err), 1);

    // Asynchronous reset with 5 outstanding
    dp_rsp_en = 0;
    rem[2] = 5;
    drive();
    repeat (6) cyc();
    chk("rst_pre_inflight", 64'(inflight_cnt), 5);
    for (int i = 0; i < N; i++) rem[i] = 0;
    dp_q.delete();
    rst = 1'b1;
    drive();
    #1;
    chk("rst_mid_inflight", 64'(inflight_cnt), 0);
    chk("rst_mid_perr", 64'(protocol_err), 0);
    chk("rst_mid_dvld", 64'(dp_data_wr_vld), 0);
    chk("rst_mid_ddata", 64'(dp_data_wr), 0);
    chk("rst_mid_rsp_vld", 64'(rsp_vld), 0);
    chk("rst_mid_dp_rsp_rdy", 64'(dp_rsp_rdy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    dp_rsp_en = 1;
    rem[3] = 1;
    drive();
    base = issue_log.size();
    run_until_idle(20, "post_rst_drain");
    chk("post_rst_issue", 64'(issue_log.size() - base), 1);
    if (issue_log.size() > base) chk("post_rst_who", 64'(issue_log[base]), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
